// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: deserialise PS/2 device-to-host frames into validated scan-code bytes
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ps2_clk   in   raw PS/2 clock pin, asynchronous to clk
//   ps2_data  in   raw PS/2 data pin, asynchronous to clk
//   data      out  last valid byte, LSB = first data bit on the wire
//   done      out  one-cycle strobe, new byte on data (data settles one clock earlier)
//   frame_err out  one-cycle strobe, frame rejected (parity, stop or timeout)
//   busy      out  frame in progress
module ps2_rx_frame #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 200000,
  parameter int TO_W       = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_STROBE = 2'd3;
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic            ck_meta_q, ck_meta_d, ck_sync_q, ck_sync_d;
  logic            dt_meta_q, dt_meta_d, dt_sync_q, dt_sync_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic            fall;
  logic [1:0]      state_q, state_d;
  logic [9:0]      frame_q, frame_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            frame_ok;
  always_comb begin
    ck_meta_d = ps2_clk;
    ck_sync_d = ck_meta_q;
    dt_meta_d = ps2_data;
    dt_sync_d = dt_meta_q;
  end
  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples;
  // any agreeing sample restarts the run, so short glitches never get through.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (ck_sync_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ck_sync_q;
      else flt_cnt_d = flt_cnt_q + FW'(1);
    end
  end
  assign fall = filt_q & ~filt_d;
  // Frame register fills from the top so that after ten shifts bit 0 holds the
  // first data bit, [8] parity and [9] stop.
  assign frame_ok = (^frame_q[8:0]) & frame_q[9];
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    to_d      = to_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && !dt_sync_q) begin
          state_d   = S_RECV;
          frame_d   = '0;
          bit_cnt_d = '0;
          to_d      = '0;
        end
      end
      S_RECV: begin
        if (fall) begin
          frame_d   = {dt_sync_q, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_d      = '0;
          state_d   = (bit_cnt_q == 4'd9) ? S_CHECK : S_RECV;
        end else if (to_q == TO_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        state_d = frame_ok ? S_STROBE : S_IDLE;
        data_d  = frame_ok ? frame_q[7:0] : data_q;
        err_d   = ~frame_ok;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_meta_q <= 1'b1;
      ck_sync_q <= 1'b1;
      dt_meta_q <= 1'b1;
      dt_sync_q <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      to_q      <= '0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ck_meta_q <= ck_meta_d;
      ck_sync_q <= ck_sync_d;
      dt_meta_q <= dt_meta_d;
      dt_sync_q <= dt_sync_d;
      filt_q    <= filt_d;
      flt_cnt_q <= flt_cnt_d;
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      to_q      <= to_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign data      = data_q;
  assign done      = done_q;
  assign frame_err = err_q;
  assign busy      = (state_q == S_RECV);
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: self-checking bench for ps2_rx_frame
module tb_ps2_rx_frame;
  localparam int FL = 8;
  localparam int TO = 600;
  localparam int HP = 40;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] data;
  logic done, frame_err, busy;
  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [7:0] data_prev = 8'h00, done_data = 8'h00, model_data = 8'h00;
  logic done_prev = 1'b0, err_prev = 1'b0;
  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       stop;
    logic       glitch;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT(TO), .TO_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .done(done), .frame_err(frame_err), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_data = data;
        check("data_settled_before_done", data, data_prev);
        check("done_err_exclusive", frame_err, 0);
        check("done_width", done_prev, 0);
      end
      if (frame_err) begin
        err_cnt++;
        check("err_width", err_prev, 0);
      end
    end
    data_prev = data;
    done_prev = done;
    err_prev  = frame_err;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wire_bit(input logic b, input logic glitch);
    ps2_data = b;
    tick(HP / 2);
    ps2_clk = 1'b0;
    tick(HP);
    ps2_clk = 1'b1;
    tick(HP / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      tick(FL - 2);
      ps2_clk = 1'b1;
      tick(HP / 2);
    end
  endtask
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] f, input logic glitch, input int first, input int last);
    for (int i = first; i <= last; i++) wire_bit(f[i], glitch);
    ps2_data = 1'b1;
  endtask
  // Reference: a frame is accepted when the data ones plus parity bit is odd and stop is 1.
  task automatic model_frame(input logic [10:0] f, output int exp_done, output int exp_err);
    int ones;
    ones = $countones(f[8:1]) + int'(f[9]);
    exp_done = ((ones % 2) == 1 && f[10]) ? 1 : 0;
    exp_err  = 1 - exp_done;
    if (exp_done == 1) model_data = f[8:1];
  endtask
  initial begin
    int d0, e0, ed, ee;
    logic [10:0] f;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 1'b0, 0, 1, 8'h1C};
    vecs[4] = '{8'h1C, 1'b0, 1'b0, 1'b0, 0, 1, 8'h1C};
    vecs[5] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1, 0, 8'h1C};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1, 0, 8'h00};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1, 0, 8'hFF};
    tick(3);
    check("reset_data", data, 8'h00);
    check("reset_done", done, 0);
    check("reset_err", frame_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(20);
    foreach (vecs[k]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      f = make_frame(vecs[k].b, vecs[k].bad_par, vecs[k].stop);
      send_bits(f, 1'b0, 0, 0);
      check("busy_after_start", busy, 1);
      send_bits(f, vecs[k].glitch, 1, 10);
      tick(40);
      check("vec_done", done_cnt - d0, vecs[k].exp_done);
      check("vec_err", err_cnt - e0, vecs[k].exp_err);
      check("vec_data", data, vecs[k].exp_data);
      check("vec_busy_end", busy, 0);
      if (vecs[k].exp_done == 1) check("vec_done_data", done_data, vecs[k].exp_data);
    end
    model_data = 8'hFF;
    for (int r = 0; r < 10; r++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      f = make_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      model_frame(f, ed, ee);
      send_bits(f, 1'b0, 0, 10);
      tick(40);
      check("rnd_done", done_cnt - d0, ed);
      check("rnd_err", err_cnt - e0, ee);
      check("rnd_data", data, model_data);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 1'b0, 0, 4);
    check("to_busy_mid", busy, 1);
    tick(TO + 10 + HP);
    check("to_err", err_cnt - e0, 1);
    check("to_done", done_cnt - d0, 0);
    check("to_busy", busy, 0);
    check("to_data", data, model_data);
    f = make_frame(8'h29, 1'b0, 1'b1);
    model_frame(f, ed, ee);
    send_bits(f, 1'b0, 0, 10);
    tick(40);
    check("after_to_done", done_cnt - d0, 1);
    check("after_to_data", data, 8'h29);
    check("after_to_err", err_cnt - e0, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    f = make_frame(8'hF0, 1'b0, 1'b1);
    send_bits(f, 1'b0, 0, 6);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", frame_err, 0);
    check("rst_mid_busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    send_bits(f, 1'b0, 7, 10);
    tick(40);
    check("rst_tail_done", done_cnt - d0, 0);
    check("rst_tail_err", err_cnt - e0, 0);
    check("rst_tail_data", data, 8'h00);
    check("rst_tail_busy", busy, 0);
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 1'b0, 0, 10);
    tick(40);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_data", data, 8'h1C);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
